program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 105 ++++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: serial byte-stream loader that fills instruction memory and holds the CPU
//   clk_i          rising-edge clock
//   reset_i        async active-high reset
//   start_i/len_i  begin a load of len_i 32-bit words
//   byte_in_i, byte_valid_i / byte_ready_o   serial byte handshake
//   im_we_o, im_addr_o, im_data_o            instruction memory write port
//   cpu_hold_o, done_o, err_o, words_loaded_o status
module program_loader #(
   parameter int DEPTH_WORDS = 128,
   parameter int ADDR_W      = 9
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [7:0]        len_i,
   input  logic [7:0]        byte_in_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_addr_o,
   output logic [31:0]       im_data_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              err_o,
   output logic [7:0]        words_loaded_o
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
   state_t            state_q, state_d;
   logic [7:0]        len_q, len_d, cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d, data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d, wa_q, wa_d;
   logic              too_big;
   assign too_big        = int'(len_i) > DEPTH_WORDS;
   assign byte_ready_o   = state_q == LOAD;
   assign im_we_o        = state_q == WRITE;
   assign cpu_hold_o     = state_q != DONE;
   assign done_o         = state_q == DONE;
   assign err_o          = err_q;
   assign words_loaded_o = cnt_q;
   // write port registers load only as WRITE is entered, so they stay put everywhere else
   assign im_addr_o      = wa_q;
   assign im_data_o      = data_q;
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wa_d    = wa_q;
      data_d  = data_q;
      case (state_q)
         IDLE, DONE: if (start_i) begin
            len_d   = len_i;
            cnt_d   = '0;
            idx_d   = '0;
            addr_d  = '0;
            err_d   = too_big;
            state_d = (len_i == 8'd0 || too_big) ? DONE : LOAD;
         end
         LOAD: if (byte_valid_i) begin
            // shifting left puts the first byte of the word in bits 31:24
            word_d = {word_q[23:0], byte_in_i};
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               wa_d    = addr_q;
               data_d  = word_d;
               state_d = WRITE;
            end
         end
         WRITE: begin
            addr_d  = addr_q + ADDR_W'(4);
            cnt_d   = cnt_q + 8'd1;
            idx_d   = '0;
            state_d = (cnt_q + 8'd1 == len_q) ? DONE : LOAD;
         end
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         wa_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wa_q    <= wa_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] len = '0;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       byte_ready, im_we, cpu_hold, done, err;
   logic [8:0] im_addr;
   logic [31:0] im_data;
   logic [7:0] words_loaded;
   int tests = 0;
   int fails = 0;
   logic [8:0]  wa[$];
   logic [31:0] wd[$];
   logic        wr[$];

   program_loader #(.DEPTH_WORDS(128), .ADDR_W(9)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .len_i(len),
      .byte_in_i(byte_in), .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
      .im_we_o(im_we), .im_addr_o(im_addr), .im_data_o(im_data),
      .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err), .words_loaded_o(words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (im_we === 1'b1) begin
      wa.push_back(im_addr);
      wd.push_back(im_data);
      wr.push_back(byte_ready);
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); wr.delete();
   endtask

   task automatic do_start(input logic [7:0] l);
      @(negedge clk); start = 1'b1; len = l; byte_valid = 1'b0;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      while (byte_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL byte_ready_timeout got 0 exp 1");
      end
      byte_in = b; byte_valid = 1'b1;
      @(posedge clk);
   endtask

   task automatic gap();
      @(negedge clk); byte_valid = 1'b0; byte_in = 8'hA5;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk); byte_valid = 1'b0;
      while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL done_timeout got %b exp 1", done); end
   endtask

   task automatic check_reset_vals(input string tag);
      tests++;
      if ({cpu_hold, byte_ready, im_we, done, err} !== 5'b10000 || im_addr !== 9'd0 ||
          im_data !== 32'd0 || words_loaded !== 8'd0) begin
         fails++;
         $display("FAIL %s got hold%b rdy%b we%b done%b err%b addr%h data%h wl%0d exp 1,0,0,0,0,0,0,0",
                  tag, cpu_hold, byte_ready, im_we, done, err, im_addr, im_data, words_loaded);
      end
   endtask

   task automatic test_reset();
      #1 check_reset_vals("reset_state");
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (im_we !== 1'b0 || cpu_hold !== 1'b1) begin
         fails++; $display("FAIL idle_after_reset got we%b hold%b exp 0,1", im_we, cpu_hold);
      end
   endtask

   task automatic test_basic();
      logic [7:0] b[8] = '{8'h34, 8'h20, 8'h00, 8'h00, 8'h08, 8'h00, 8'h02, 8'h40};
      clear_log();
      do_start(8'd2);
      foreach (b[i]) send_byte(b[i]);
      wait_done();
      tests++;
      if (wa.size() != 2) begin fails++; $display("FAIL basic_count got %0d exp 2", wa.size()); end
      else begin
         tests++;
         if (wa[0] !== 9'd0 || wd[0] !== 32'h34200000) begin
            fails++; $display("FAIL basic_w0 got %h/%h exp 000/34200000", wa[0], wd[0]);
         end
         tests++;
         if (wa[1] !== 9'd4 || wd[1] !== 32'h08000240) begin
            fails++; $display("FAIL basic_w1 got %h/%h exp 004/08000240", wa[1], wd[1]);
         end
      end
      tests++;
      if (cpu_hold !== 1'b0 || words_loaded !== 8'd2 || err !== 1'b0) begin
         fails++; $display("FAIL basic_status got hold%b wl%0d err%b exp 0,2,0", cpu_hold, words_loaded, err);
      end
   endtask

   task automatic test_gaps();
      clear_log();
      do_start(8'd1);
      send_byte(8'hDE); gap(); send_byte(8'hAD); gap(); gap();
      send_byte(8'hBE); gap(); send_byte(8'hEF);
      wait_done();
      tests++;
      if (wa.size() != 1 || wd[0] !== 32'hDEADBEEF || wa[0] !== 9'd0) begin
         fails++; $display("FAIL gaps_word got n%0d %h exp 1 DEADBEEF", wa.size(), wd.size() ? wd[0] : 32'hx);
      end
      tests++;
      if (wr.size() != 1 || wr[0] !== 1'b0) begin
         fails++; $display("FAIL gaps_ready_in_write got %b exp 0", wr.size() ? wr[0] : 1'bx);
      end
   endtask

   task automatic test_len0();
      clear_log();
      do_start(8'd0);
      tests++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0 || words_loaded !== 8'd0) begin
         fails++; $display("FAIL len0 got done%b hold%b err%b wl%0d exp 1,0,0,0", done, cpu_hold, err, words_loaded);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (wa.size() != 0) begin fails++; $display("FAIL len0_nowrite got %0d exp 0", wa.size()); end
   endtask

   task automatic test_overflow();
      clear_log();
      do_start(8'd129);
      tests++;
      if (done !== 1'b1 || err !== 1'b1 || words_loaded !== 8'd0) begin
         fails++; $display("FAIL ovf got done%b err%b wl%0d exp 1,1,0", done, err, words_loaded);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (wa.size() != 0 || err !== 1'b1) begin
         fails++; $display("FAIL ovf_hold got n%0d err%b exp 0,1", wa.size(), err);
      end
   endtask

   task automatic test_len128();
      clear_log();
      do_start(8'd128);
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL len128_err got %b exp 0", err); end
      for (int i = 0; i < 512; i++) send_byte(i[7:0]);
      wait_done();
      tests++;
      if (wa.size() != 128 || words_loaded !== 8'd128) begin
         fails++; $display("FAIL len128_count got n%0d wl%0d exp 128", wa.size(), words_loaded);
      end else begin
         tests++;
         if (wd[0] !== 32'h00010203 || wa[127] !== 9'd508 || wd[127] !== 32'hFCFDFEFF) begin
            fails++; $display("FAIL len128_words got %h %h/%h exp 00010203 1fc/fcfdfeff", wd[0], wa[127], wd[127]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      do_start(8'd1);
      send_byte(8'h11); send_byte(8'h22);
      @(negedge clk); reset = 1'b1; byte_valid = 1'b0;
      #1 check_reset_vals("reset_mid");
      @(negedge clk); reset = 1'b0; byte_valid = 1'b1; byte_in = 8'h77;
      repeat (4) @(negedge clk);
      byte_valid = 1'b0;
      tests++;
      if (wa.size() != 0) begin fails++; $display("FAIL reset_nowrite got %0d exp 0", wa.size()); end
      do_start(8'd1);
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
      wait_done();
      tests++;
      if (wa.size() != 1 || wa[0] !== 9'd0 || wd[0] !== 32'hCAFEBABE) begin
         fails++; $display("FAIL reset_restart got n%0d %h exp 1 CAFEBABE", wa.size(), wd.size() ? wd[0] : 32'hx);
      end
   endtask

   task automatic test_reload_ignore();
      clear_log();
      do_start(8'd2);
      send_byte(8'h01); send_byte(8'h02);
      do_start(8'd5);
      send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      wait_done();
      tests++;
      if (wa.size() != 2 || words_loaded !== 8'd2 || wd[0] !== 32'h01020304 || wd[1] !== 32'h05060708) begin
         fails++; $display("FAIL start_in_load got n%0d wl%0d exp 2 writes 01020304 05060708", wa.size(), words_loaded);
      end
      clear_log();
      do_start(8'd1);
      tests++;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== 8'd0) begin
         fails++; $display("FAIL reload_status got hold%b done%b wl%0d exp 1,0,0", cpu_hold, done, words_loaded);
      end
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
      wait_done();
      tests++;
      if (wa.size() != 1 || wa[0] !== 9'd0 || wd[0] !== 32'h9ABCDEF0) begin
         fails++; $display("FAIL reload_write got n%0d exp 1 at 000 9ABCDEF0", wa.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_len0();
      test_overflow();
      test_len128();
      test_reset_mid();
      test_reload_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
